pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register for the 5-stage core; successor to the fixed ID/EX latch. It carries one generic control field and one generic data field per stage with valid/ready handshaking, synchronous flush, and automatic control zeroing on bubbles. Each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) gets one instance. A compile-time option adds a second skid entry so that `in_ready` carries no combinational path from `out_ready`.

## Interface
Parameters:
- CTRL_W, default 16: width of the control field (alu_ctrl, mem_read/write, reg_write, branch/jump bits, etc.). This field is zeroed whenever its entry is invalid.
- DATA_W, default 112: width of the data field (operands, imm, shamt, reg ids, pc_plus4). It is never cleared except by reset.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous kill of all held entries and of the current input.
- in_valid, input, 1: upstream holds a valid entry.
- in_ready, output, 1: this stage accepts the entry this cycle.
- in_ctrl, input, CTRL_W: upstream control field.
- in_data, input, DATA_W: upstream data field.
- out_valid, output, 1: the head entry is valid.
- out_ready, input, 1: downstream consumes the head this cycle.
- out_ctrl, output, CTRL_W: head control field; all-zero when out_valid=0.
- out_data, output, DATA_W: head data field; value is don't-care when out_valid=0.
- occ, output, 2: number of held entries (0..1 without skid, 0..2 with skid).

## Operation
- Accept when in_valid && in_ready. Release when out_valid && out_ready.
- Stall is expressed as out_ready=0. The head entry holds; nothing is duplicated or lost.
- A bubble is an invalid entry. On a bubble, out_ctrl is forced to 0, so downstream sees no reg_write, mem_read, mem_write, branch or jump.
- Flush has priority over every other input:
  - All entries become invalid next cycle and occ becomes 0.
  - in_ready is forced to 0 in the flush cycle, so the input is dropped.
  - Data registers keep their old values.
- Single-entry mode (no macro):
  - in_ready = !flush && (!out_valid || out_ready). Simultaneous accept and release replaces the entry.
- Skid mode, states EMPTY, ONE, TWO:
  - EMPTY: accept moves to ONE.
  - ONE: accept without release moves to TWO. Release without accept moves to EMPTY. Accept with release stays in ONE.
  - TWO: release moves to ONE, and the skid entry is promoted to head. Accept is impossible here because in_ready=0.
  - Entries leave in FIFO order.
- Flush in any state goes to EMPTY.
- Reset: out_valid=0, out_ctrl=0, out_data=0, occ=0, in_ready=0 while reset_n is low. Internal skid storage is also zeroed.

## Timing
- Latency is 1 cycle from accept to out_valid, in both modes.
- Throughput is 1 entry per cycle while out_ready=1.
- Single-entry mode: in_ready depends combinationally on out_ready and flush.
- Skid mode: in_ready = !flush && (state != TWO), computed from registered state only. The only combinational input is flush.
- Asserting reset_n low mid-transfer clears everything immediately, without waiting for clk. The first accept is possible on the first rising edge after deassertion.
- out_ctrl and out_valid change only on clk edges or on reset assertion.

## Configuration
- PIPE_SKID_EN defined: two entries, FSM as described above, and a registered-state in_ready.
- PIPE_SKID_EN undefined: single entry, no FSM, combinational in_ready. occ is limited to 0..1; the occ[1] bit ties to 0.

## Structure
- Package pipe_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e.
  - Default CTRL_W and DATA_W localparams for each stage boundary.
- Sub-module pipe_stage_slot: one storage entry (valid, ctrl, data) with load and kill inputs and ctrl zeroing when invalid. It is instantiated once, or twice under PIPE_SKID_EN.

## Test plan
- Reset mid-stream:
  - Stimulus: with out_valid=1 and out_ctrl=16'h00A5, pull reset_n low between edges.
  - Response: out_valid=0, out_ctrl=0, out_data=0 and occ=0 before the next edge; in_ready=0 until release.
- Streaming:
  - Stimulus: in_valid=1 with in_ctrl = 1,2,3,4 on consecutive cycles, out_ready=1.
  - Response: out_ctrl = 1,2,3,4 one cycle later each, with no gaps.
- Stall:
  - Stimulus: hold out_ready=0 for 3 cycles with in_valid=1.
  - Response without skid: head holds and in_ready=0.
  - Response with skid: occ reaches 2 and then in_ready=0.
  - On out_ready=1: the entries emerge in order and none are lost.
- Bubble:
  - Stimulus: in_valid=0 with in_ctrl=16'hFFFF.
  - Response: next cycle out_valid=0 and out_ctrl=0.
- Flush priority:
  - Stimulus: in state TWO (skid), assert flush together with in_valid=1 and out_ready=1.
  - Response: in_ready=0 that cycle; next cycle occ=0, out_valid=0 and out_ctrl=0; the dropped entry never appears.
- Simultaneous accept and release in ONE:
  - Stimulus: in_ctrl=7 is accepted while head ctrl=6 is released.
  - Response: occ stays 1 and out_ctrl=7 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and per-boundary field widths for the 5-stage core pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int PIPE_CTRL_W   = 16;
  localparam int PIPE_DATA_W   = 112;

  localparam int IF_ID_CTRL_W  = 16;
  localparam int IF_ID_DATA_W  = 112;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int ID_EX_DATA_W  = 112;
  localparam int EX_MEM_CTRL_W = 16;
  localparam int EX_MEM_DATA_W = 112;
  localparam int MEM_WB_CTRL_W = 16;
  localparam int MEM_WB_DATA_W = 112;

  // Held-entry count from the skid FSM state.
  function automatic logic [1:0] state_occ(input skid_state_e s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline storage entry: valid bit, control field (zeroed whenever invalid) and data field.
module pipe_stage_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 112
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              kill,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] data_reg;

  // Kill beats load beats clear; data only ever changes on load or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else if (kill) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      ctrl_reg  <= load_ctrl;
      data_reg  <= load_data;
    end else if (clear) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end
  end

  assign valid = valid_reg;
  assign ctrl  = ctrl_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with flush and bubble control zeroing.
// Define PIPE_SKID_EN for a two-entry skid version whose in_ready is registered-state only.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic accept;
  logic rel;

  assign accept = in_valid && in_ready;
  assign rel    = out_valid && out_ready;

`ifdef PIPE_SKID_EN

  skid_state_e       state_reg;
  skid_state_e       state_next;
  logic              head_load;
  logic              head_clear;
  logic              skid_load;
  logic              skid_clear;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] head_src_ctrl;
  logic [DATA_W-1:0] head_src_data;

  // reset_n gating keeps in_ready low while reset is held.
  assign in_ready = reset_n && !flush && (state_reg != TWO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    head_load     = 1'b0;
    head_clear    = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    head_src_ctrl = in_ctrl;
    head_src_data = in_data;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          head_load  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && rel) begin
          head_load = 1'b1;
        end else if (accept) begin
          skid_load  = 1'b1;
          state_next = TWO;
        end else if (rel) begin
          head_clear = 1'b1;
          state_next = EMPTY;
        end
      end
      TWO: begin
        // Promote the skid entry to head; in_ready is low so nothing enters.
        if (rel) begin
          head_load     = 1'b1;
          head_src_ctrl = skid_ctrl;
          head_src_data = skid_data;
          skid_clear    = 1'b1;
          state_next    = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next = EMPTY;
    end
  end

  pipe_stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_head (
    .clk       (clk),
    .reset_n   (reset_n),
    .kill      (flush),
    .load      (head_load),
    .clear     (head_clear),
    .load_ctrl (head_src_ctrl),
    .load_data (head_src_data),
    .valid     (out_valid),
    .ctrl      (out_ctrl),
    .data      (out_data)
  );

  pipe_stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .kill      (flush),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_ctrl (in_ctrl),
    .load_data (in_data),
    .valid     (skid_valid),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );

  // The skid slot is only ever valid in TWO, so its valid bit selects that count.
  assign occ = skid_valid ? 2'd2 : state_occ(state_reg);

`else

  assign in_ready = reset_n && !flush && (!out_valid || out_ready);

  pipe_stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_head (
    .clk       (clk),
    .reset_n   (reset_n),
    .kill      (flush),
    .load      (accept),
    .clear     (rel),
    .load_ctrl (in_ctrl),
    .load_data (in_data),
    .valid     (out_valid),
    .ctrl      (out_ctrl),
    .data      (out_data)
  );

  assign occ = {1'b0, out_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; works in both default and PIPE_SKID_EN builds.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 112;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;

  pipe_stage_reg #(
    .CTRL_W (CW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } entry_t;

  entry_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle: drive at negedge, compare head against the scoreboard, update the model.
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic ordy, input logic fl);
    entry_t e;
    logic   exp_rdy;
    logic   acc;
    logic   rel;
    @(negedge clk);
    e.c = ic;
    e.d = {ic, $urandom(), $urandom(), $urandom()};
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = e.d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_eq("occ", {126'd0, occ}, 128'(q.size()));
    check_eq("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
    if (q.size() != 0) begin
      check_eq("out_ctrl", {112'd0, out_ctrl}, {112'd0, q[0].c});
      check_eq("out_data", {16'd0, out_data}, {16'd0, q[0].d});
    end else begin
      check_eq("bubble_ctrl", {112'd0, out_ctrl}, 128'd0);
    end
    if (fl) begin
      check_eq("flush_in_ready", {127'd0, in_ready}, 128'd0);
      q.delete();
      $display("flush: all entries dropped, input ctrl=%h dropped", ic);
    end else begin
`ifdef PIPE_SKID_EN
      exp_rdy = q.size() < 2;
`else
      exp_rdy = (q.size() == 0) || ordy;
`endif
      check_eq("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
      rel = (q.size() != 0) && ordy;
      acc = iv && exp_rdy;
      if (rel) begin
        $display("release ctrl=%h", q[0].c);
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(e);
        $display("accept  ctrl=%h", ic);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
    check_eq({tag, "_out_ctrl"}, {112'd0, out_ctrl}, 128'd0);
    check_eq({tag, "_out_data"}, {16'd0, out_data}, 128'd0);
    check_eq({tag, "_occ"}, {126'd0, occ}, 128'd0);
    check_eq({tag, "_in_ready"}, {127'd0, in_ready}, 128'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check_cleared("por");
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // Reset mid-stream, asserted between edges.
    step(1'b1, 16'h00A5, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_cleared("async_rst");
    q.delete();
    @(posedge clk);
    #1;
    check_cleared("rst_held");
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming.
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Stall for three cycles, then drain.
    step(1'b1, 16'h0010, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h0011 + k), 1'b0, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Bubble.
    step(1'b0, 16'hFFFF, 1'b1, 1'b0);
    step(1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Flush with a full stage and a valid input.
    step(1'b1, 16'h0020, 1'b0, 1'b0);
    step(1'b1, 16'h0021, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1);
    step(1'b1, 16'h0030, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Simultaneous accept and release with one entry held.
    step(1'b1, 16'h0006, 1'b0, 1'b0);
    step(1'b1, 16'h0007, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic.
    for (int r = 0; r < 80; r++)
      step(1'($urandom_range(0, 1)), 16'($urandom()), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    repeat (4) step(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
